// File: rtl/bp_me_mem_responder.sv
// Single-outstanding CCE memory responder backed by a block array with fixed access latency.
// Optional BP_ME_MEM_CRIT_WORD_FIRST_EN: cached reads return the addressed 64-bit word in data[63:0].
module bp_me_mem_responder #(
   parameter int paddr_width_p   = 40,
   parameter int block_width_p   = 512,
   parameter int mem_els_p       = 1024,
   parameter int payload_width_p = 16,
   parameter int latency_p       = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       mem_cmd_v_i,
   output logic                       mem_cmd_ready_o,
   input  logic [1:0]                 mem_cmd_type_i,
   input  logic [1:0]                 mem_cmd_size_i,
   input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
   input  logic [payload_width_p-1:0] mem_cmd_payload_i,
   input  logic [block_width_p-1:0]   mem_cmd_data_i,
   output logic                       mem_resp_v_o,
   input  logic                       mem_resp_yumi_i,
   output logic [1:0]                 mem_resp_type_o,
   output logic [1:0]                 mem_resp_size_o,
   output logic [paddr_width_p-1:0]   mem_resp_addr_o,
   output logic [payload_width_p-1:0] mem_resp_payload_o,
   output logic [block_width_p-1:0]   mem_resp_data_o
);

   localparam int block_bytes_lp = block_width_p / 8;
   localparam int offset_w_lp    = $clog2(block_bytes_lp);
   localparam int idx_w_lp       = $clog2(mem_els_p);
   localparam int cnt_w_lp       = (latency_p > 1) ? $clog2(latency_p) : 1;

   typedef enum logic [1:0] {
      e_idle   = 2'd0,
      e_access = 2'd1,
      e_resp   = 2'd2
   } state_e;

   state_e                     state_q, state_d;
   logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
   logic [1:0]                 type_q, type_d;
   logic [1:0]                 size_q, size_d;
   logic [paddr_width_p-1:0]   addr_q, addr_d;
   logic [payload_width_p-1:0] payload_q, payload_d;
   logic [block_width_p-1:0]   wdata_q, wdata_d;
   logic [block_width_p-1:0]   resp_data_q, resp_data_d;

   logic                       mem_we;
   logic [block_width_p-1:0]   mem_r [mem_els_p];
   logic [idx_w_lp-1:0]        idx;
   logic [offset_w_lp-1:0]     off_al;
   logic [block_width_p-1:0]   rd_block, wr_block, rd_data, uc_shifted;
`ifdef BP_ME_MEM_CRIT_WORD_FIRST_EN
   logic [2*block_width_p-1:0] rot_dbl;
`endif

   function automatic logic [63:0] uc_mask(input logic [1:0] size);
      case (size)
         2'd0:    return 64'h0000_0000_0000_00FF;
         2'd1:    return 64'h0000_0000_0000_FFFF;
         2'd2:    return 64'h0000_0000_FFFF_FFFF;
         default: return 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
   endfunction

   function automatic logic [offset_w_lp-1:0] align_off(input logic [offset_w_lp-1:0] off,
                                                        input logic [1:0]             size);
      logic [offset_w_lp-1:0] low_bits;
      low_bits = offset_w_lp'((1 << size) - 1);
      return off & ~low_bits;
   endfunction

   always_comb begin
      idx        = addr_q[offset_w_lp +: idx_w_lp];
      rd_block   = mem_r[idx];
      off_al     = align_off(addr_q[offset_w_lp-1:0], size_q);
      uc_shifted = rd_block >> {off_al, 3'b000};
      wr_block   = rd_block;
      rd_data    = rd_block;
`ifdef BP_ME_MEM_CRIT_WORD_FIRST_EN
      rot_dbl    = {rd_block, rd_block} >> (int'(addr_q[offset_w_lp-1:0] >> 3) * 64);
`endif
      if (type_q[1]) begin
         // Uncached: only the 2^size aligned bytes are visible or modified.
         rd_data       = '0;
         rd_data[63:0] = uc_shifted[63:0] & uc_mask(size_q);
         for (int b = 0; b < 8; b++) begin
            if (b < (1 << size_q)) begin
               wr_block[(int'(off_al) + b) * 8 +: 8] = wdata_q[b * 8 +: 8];
            end
         end
      end else begin
         wr_block = wdata_q;
`ifdef BP_ME_MEM_CRIT_WORD_FIRST_EN
         rd_data  = rot_dbl[block_width_p-1:0];
`else
         rd_data  = rd_block;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      type_d      = type_q;
      size_d      = size_q;
      addr_d      = addr_q;
      payload_d   = payload_q;
      wdata_d     = wdata_q;
      resp_data_d = resp_data_q;
      mem_we      = 1'b0;
      case (state_q)
         e_idle: begin
            if (mem_cmd_v_i) begin
               type_d    = mem_cmd_type_i;
               size_d    = mem_cmd_size_i;
               addr_d    = mem_cmd_addr_i;
               payload_d = mem_cmd_payload_i;
               wdata_d   = mem_cmd_data_i;
               cnt_d     = cnt_w_lp'(latency_p - 1);
               state_d   = e_access;
            end
         end
         e_access: begin
            if (cnt_q == '0) begin
               mem_we      = type_q[0];
               resp_data_d = type_q[0] ? '0 : rd_data;
               state_d     = e_resp;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         e_resp: begin
            if (mem_resp_yumi_i) begin
               state_d = e_idle;
            end
         end
         default: state_d = e_idle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= e_idle;
         cnt_q       <= '0;
         type_q      <= '0;
         size_q      <= '0;
         addr_q      <= '0;
         payload_q   <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         type_q      <= type_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         payload_q   <= payload_d;
         resp_data_q <= resp_data_d;
      end
   end

   // Write data only matters while a command is in flight, so it carries no reset.
   always_ff @(posedge clk_i) begin
      wdata_q <= wdata_d;
   end

   // Write gated by state_q, so a reset during ACCESS cancels the pending update.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_r[idx] <= wr_block;
      end
   end

   assign mem_cmd_ready_o    = (state_q == e_idle) & reset_n_i;
   assign mem_resp_v_o       = (state_q == e_resp);
   assign mem_resp_type_o    = type_q;
   assign mem_resp_size_o    = size_q;
   assign mem_resp_addr_o    = addr_q;
   assign mem_resp_payload_o = payload_q;
   assign mem_resp_data_o    = resp_data_q;

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// Scoreboard bench for bp_me_mem_responder: expected responses queued at command time, checked on response.
module tb_bp_me_mem_responder;

   localparam int PW  = 40;
   localparam int BW  = 512;
   localparam int ELS = 1024;
   localparam int PLW = 16;
   localparam int LAT = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic           cmd_v = 1'b0;
   logic           cmd_ready;
   logic [1:0]     cmd_type = '0;
   logic [1:0]     cmd_size = '0;
   logic [PW-1:0]  cmd_addr = '0;
   logic [PLW-1:0] cmd_payload = '0;
   logic [BW-1:0]  cmd_data = '0;
   logic           resp_v;
   logic           resp_yumi = 1'b0;
   logic [1:0]     resp_type;
   logic [1:0]     resp_size;
   logic [PW-1:0]  resp_addr;
   logic [PLW-1:0] resp_payload;
   logic [BW-1:0]  resp_data;

   typedef struct {
      logic [1:0]     t;
      logic [1:0]     sz;
      logic [PW-1:0]  a;
      logic [PLW-1:0] pl;
      logic [BW-1:0]  d;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   cyc    = 0;
   int   acc_cyc = 0;

   bp_me_mem_responder #(
      .paddr_width_p  (PW),
      .block_width_p  (BW),
      .mem_els_p      (ELS),
      .payload_width_p(PLW),
      .latency_p      (LAT)
   ) dut (
      .clk_i             (clk),
      .reset_n_i         (reset_n),
      .mem_cmd_v_i       (cmd_v),
      .mem_cmd_ready_o   (cmd_ready),
      .mem_cmd_type_i    (cmd_type),
      .mem_cmd_size_i    (cmd_size),
      .mem_cmd_addr_i    (cmd_addr),
      .mem_cmd_payload_i (cmd_payload),
      .mem_cmd_data_i    (cmd_data),
      .mem_resp_v_o      (resp_v),
      .mem_resp_yumi_i   (resp_yumi),
      .mem_resp_type_o   (resp_type),
      .mem_resp_size_o   (resp_size),
      .mem_resp_addr_o   (resp_addr),
      .mem_resp_payload_o(resp_payload),
      .mem_resp_data_o   (resp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      else n_pass++;
   endtask

   function automatic logic [BW-1:0] mk_blk(input logic [31:0] seed);
      logic [BW-1:0] b;
      for (int i = 0; i < BW / 64; i++) b[i*64 +: 64] = {seed + 32'(i), ~(seed + 32'(i))};
      return b;
   endfunction

   function automatic logic [BW-1:0] crit_rd(input logic [BW-1:0] blk, input logic [PW-1:0] a);
      logic [BW-1:0] r;
      int w;
      r = blk;
`ifdef BP_ME_MEM_CRIT_WORD_FIRST_EN
      w = int'(a[5:3]);
      for (int i = 0; i < BW / 64; i++) r[i*64 +: 64] = blk[((i + w) % (BW / 64))*64 +: 64];
`else
      w = int'(a[5:3]);
      if (w > BW) r = '0;
`endif
      return r;
   endfunction

   task automatic send(input logic [1:0] t, input logic [1:0] sz, input logic [PW-1:0] a,
                       input logic [PLW-1:0] pl, input logic [BW-1:0] d,
                       input logic [BW-1:0] exp_d, input bit push);
      int n;
      if (push) exp_q.push_back('{t: t, sz: sz, a: a, pl: pl, d: exp_d});
      @(negedge clk);
      cmd_v = 1'b1; cmd_type = t; cmd_size = sz; cmd_addr = a; cmd_payload = pl; cmd_data = d;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check_val("cmd_ready_tmo", {511'd0, cmd_ready}, 512'd1);
      @(negedge clk);
      acc_cyc = cyc;
      cmd_v = 1'b0;
   endtask

   task automatic recv(input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!resp_v && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("resp_v", {511'd0, resp_v}, 512'd1);
      check_val("latency", BW'(cyc - acc_cyc), BW'(LAT));
      if (exp_q.size() == 0) begin
         check_val("sb_empty", BW'(exp_q.size()), 512'd1);
      end else begin
         e = exp_q.pop_front();
         check_val("resp_type", {510'd0, resp_type}, {510'd0, e.t});
         check_val("resp_size", {510'd0, resp_size}, {510'd0, e.sz});
         check_val("resp_addr", BW'(resp_addr), BW'(e.a));
         check_val("resp_payload", BW'(resp_payload), BW'(e.pl));
         check_val("resp_data", resp_data, e.d);
         for (int h = 0; h < hold; h++) begin
            cmd_v = 1'b1; cmd_type = 2'd1; cmd_addr = 40'h80; cmd_data = '1;
            @(negedge clk);
            check_val("hold_v", {511'd0, resp_v}, 512'd1);
            check_val("hold_ready", {511'd0, cmd_ready}, 512'd0);
            check_val("hold_data", resp_data, e.d);
            check_val("hold_addr", BW'(resp_addr), BW'(e.a));
         end
      end
      cmd_v = 1'b0;
      resp_yumi = 1'b1;
      @(negedge clk);
      resp_yumi = 1'b0;
      check_val("ready_after_yumi", {511'd0, cmd_ready}, 512'd1);
      check_val("v_after_yumi", {511'd0, resp_v}, 512'd0);
   endtask

   initial begin
      logic [BW-1:0] p, q1, q2, z;
      z = '0;
      p = mk_blk(32'hA5A5_0000);
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", {511'd0, cmd_ready}, 512'd0);
      check_val("rst_v", {511'd0, resp_v}, 512'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("idle_ready", {511'd0, cmd_ready}, 512'd1);
      check_val("idle_v", {511'd0, resp_v}, 512'd0);
      check_val("idle_addr", BW'(resp_addr), 512'd0);
      check_val("idle_data", resp_data, 512'd0);

      // Cached write then read back
      send(2'd1, 2'd0, 40'h80, 16'h1111, p, z, 1'b1); recv(0);
      send(2'd0, 2'd3, 40'h80, 16'h1234, z, p, 1'b1); recv(0);

      // Uncached byte write onto a zeroed block
      send(2'd1, 2'd0, 40'h80, 16'h0001, z, z, 1'b1); recv(0);
      send(2'd3, 2'd0, 40'h83, 16'h0002, {{504{1'b1}}, 8'hAB}, z, 1'b1); recv(0);
      send(2'd2, 2'd3, 40'h80, 16'h0003, '1, {448'd0, 64'h0000_0000_AB00_0000}, 1'b1); recv(0);

      // Uncached 8B and misaligned 2B writes, then sized reads
      send(2'd3, 2'd3, 40'h80, 16'h0004, {{448{1'b1}}, 64'h8877_6655_4433_2211}, z, 1'b1); recv(0);
      send(2'd3, 2'd1, 40'h85, 16'h0005, {{496{1'b1}}, 16'hBEEF}, z, 1'b1); recv(0);
      send(2'd2, 2'd3, 40'h80, 16'h0006, z, {448'd0, 64'h8877_BEEF_4433_2211}, 1'b1); recv(0);
      send(2'd2, 2'd2, 40'h86, 16'h0007, z, {480'd0, 32'h8877_BEEF}, 1'b1); recv(10);
      send(2'd2, 2'd0, 40'h87, 16'h0008, z, {504'd0, 8'h88}, 1'b1); recv(0);

      // Aliasing: upper address bits ignored
      q1 = mk_blk(32'h1000_0000);
      q2 = mk_blk(32'h2000_0000);
      send(2'd1, 2'd0, 40'h2040, 16'h0009, q1, z, 1'b1); recv(0);
      send(2'd1, 2'd0, 40'h2040 + 40'(ELS * (BW / 8)), 16'h000A, q2, z, 1'b1); recv(0);
      send(2'd0, 2'd0, 40'h2040, 16'h000B, z, q2, 1'b1); recv(0);

      // Cached read of a non-aligned address
      send(2'd1, 2'd0, 40'h80, 16'h000C, p, z, 1'b1); recv(0);
      send(2'd0, 2'd0, 40'h98, 16'h000D, z, crit_rd(p, 40'h98), 1'b1); recv(0);

      // Reset during ACCESS of a write cancels it
      send(2'd1, 2'd0, 40'h1000, 16'h000E, q1, z, 1'b1); recv(0);
      send(2'd1, 2'd0, 40'h1000, 16'h000F, q2, z, 1'b0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_val("midrst_ready", {511'd0, cmd_ready}, 512'd0);
      check_val("midrst_v", {511'd0, resp_v}, 512'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      check_val("postrst_ready", {511'd0, cmd_ready}, 512'd1);
      check_val("postrst_v", {511'd0, resp_v}, 512'd0);
      send(2'd0, 2'd0, 40'h1000, 16'h0010, z, q1, 1'b1); recv(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
